// File: rtl/peripheral_axi4_read_arbiter.sv
// peripheral_axi4_read_arbiter: round-robin 2:1 AXI4 read arbiter, one burst outstanding
module peripheral_axi4_read_arbiter #(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      m0_arvalid,
  output logic                      m0_arready,
  input  logic [AXI_ADDR_WIDTH-1:0] m0_araddr,
  input  logic [AXI_ID_WIDTH-1:0]   m0_arid,
  input  logic [7:0]                m0_arlen,
  input  logic [2:0]                m0_arsize,
  input  logic [1:0]                m0_arburst,
  output logic                      m0_rvalid,
  input  logic                      m0_rready,
  output logic [AXI_DATA_WIDTH-1:0] m0_rdata,
  output logic [AXI_ID_WIDTH-1:0]   m0_rid,
  output logic [1:0]                m0_rresp,
  output logic                      m0_rlast,
  input  logic                      m1_arvalid,
  output logic                      m1_arready,
  input  logic [AXI_ADDR_WIDTH-1:0] m1_araddr,
  input  logic [AXI_ID_WIDTH-1:0]   m1_arid,
  input  logic [7:0]                m1_arlen,
  input  logic [2:0]                m1_arsize,
  input  logic [1:0]                m1_arburst,
  output logic                      m1_rvalid,
  input  logic                      m1_rready,
  output logic [AXI_DATA_WIDTH-1:0] m1_rdata,
  output logic [AXI_ID_WIDTH-1:0]   m1_rid,
  output logic [1:0]                m1_rresp,
  output logic                      m1_rlast,
  output logic                      s_arvalid,
  input  logic                      s_arready,
  output logic [AXI_ADDR_WIDTH-1:0] s_araddr,
  output logic [AXI_ID_WIDTH-1:0]   s_arid,
  output logic [7:0]                s_arlen,
  output logic [2:0]                s_arsize,
  output logic [1:0]                s_arburst,
  input  logic                      s_rvalid,
  output logic                      s_rready,
  input  logic [AXI_DATA_WIDTH-1:0] s_rdata,
  input  logic [AXI_ID_WIDTH-1:0]   s_rid,
  input  logic [1:0]                s_rresp,
  input  logic                      s_rlast,
  output logic [1:0]                gnt,
  output logic                      busy
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state_q, state_d;
  logic owner_q, owner_d, last_q, last_d;
  logic in_addr, in_data, a0, a1, d0, d1;
  // state, owner and round-robin history; last starts at 1 so master 0 wins the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end
  // arbitration in IDLE, then address phase, then data phase until the last beat
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    if (state_q == IDLE && (m0_arvalid || m1_arvalid)) begin
      owner_d = (m0_arvalid && m1_arvalid) ? ~last_q : m1_arvalid;
      last_d  = owner_d;
      state_d = ADDR;
    end else if (state_q == ADDR && s_arvalid && s_arready) begin
      state_d = DATA;
    end else if (state_q == DATA && s_rvalid && s_rready && s_rlast) begin
      state_d = IDLE;
    end
  end
  assign in_addr = state_q == ADDR;
  assign in_data = state_q == DATA;
  assign a0 = in_addr & ~owner_q;
  assign a1 = in_addr & owner_q;
  assign d0 = in_data & ~owner_q;
  assign d1 = in_data & owner_q;
  assign busy = state_q != IDLE;
  assign gnt = {busy & owner_q, busy & ~owner_q};
  assign s_arvalid = (a0 & m0_arvalid) | (a1 & m1_arvalid);
  assign s_araddr  = a0 ? m0_araddr  : a1 ? m1_araddr  : '0;
  assign s_arid    = a0 ? m0_arid    : a1 ? m1_arid    : '0;
  assign s_arlen   = a0 ? m0_arlen   : a1 ? m1_arlen   : '0;
  assign s_arsize  = a0 ? m0_arsize  : a1 ? m1_arsize  : '0;
  assign s_arburst = a0 ? m0_arburst : a1 ? m1_arburst : '0;
  assign m0_arready = a0 & s_arready;
  assign m1_arready = a1 & s_arready;
  assign s_rready  = (d0 & m0_rready) | (d1 & m1_rready);
  assign m0_rvalid = d0 & s_rvalid;
  assign m0_rdata  = d0 ? s_rdata : '0;
  assign m0_rid    = d0 ? s_rid : '0;
  assign m0_rresp  = d0 ? s_rresp : '0;
  assign m0_rlast  = d0 & s_rlast;
  assign m1_rvalid = d1 & s_rvalid;
  assign m1_rdata  = d1 ? s_rdata : '0;
  assign m1_rid    = d1 ? s_rid : '0;
  assign m1_rresp  = d1 ? s_rresp : '0;
  assign m1_rlast  = d1 & s_rlast;
endmodule

// File: tb/tb_peripheral_axi4_read_arbiter.sv
// tb_peripheral_axi4_read_arbiter: randomized traffic against a burst-level arbiter model
module tb_peripheral_axi4_read_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] mav = '0, mrr = '0, marr, mrv, mrl;
  logic [1:0][63:0] maddr = '0, mrd;
  logic [1:0][3:0] mid = '0, mrid;
  logic [1:0][7:0] mlen = '0;
  logic [1:0][2:0] msize = '0;
  logic [1:0][1:0] mburst = '0, mrresp;
  logic s_arready = 1'b0, s_rvalid = 1'b0, s_rlast = 1'b0;
  logic [63:0] s_rdata = '0;
  logic [3:0] s_rid = '0;
  logic [1:0] s_rresp = '0;
  logic sav, srr, busy;
  logic [63:0] saddr;
  logic [3:0] said;
  logic [7:0] salen;
  logic [2:0] sasize;
  logic [1:0] saburst, gnt;
  int n_chk = 0, n_fail = 0;
  bit busy_m, addr_m, own, last, tie;
  bit [1:0] hs;
  int beats, len_m;

  peripheral_axi4_read_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_arvalid(mav[0]), .m0_arready(marr[0]), .m0_araddr(maddr[0]), .m0_arid(mid[0]),
    .m0_arlen(mlen[0]), .m0_arsize(msize[0]), .m0_arburst(mburst[0]),
    .m0_rvalid(mrv[0]), .m0_rready(mrr[0]), .m0_rdata(mrd[0]), .m0_rid(mrid[0]),
    .m0_rresp(mrresp[0]), .m0_rlast(mrl[0]),
    .m1_arvalid(mav[1]), .m1_arready(marr[1]), .m1_araddr(maddr[1]), .m1_arid(mid[1]),
    .m1_arlen(mlen[1]), .m1_arsize(msize[1]), .m1_arburst(mburst[1]),
    .m1_rvalid(mrv[1]), .m1_rready(mrr[1]), .m1_rdata(mrd[1]), .m1_rid(mrid[1]),
    .m1_rresp(mrresp[1]), .m1_rlast(mrl[1]),
    .s_arvalid(sav), .s_arready(s_arready), .s_araddr(saddr), .s_arid(said),
    .s_arlen(salen), .s_arsize(sasize), .s_arburst(saburst),
    .s_rvalid(s_rvalid), .s_rready(srr), .s_rdata(s_rdata), .s_rid(s_rid),
    .s_rresp(s_rresp), .s_rlast(s_rlast),
    .gnt(gnt), .busy(busy)
  );

  // free-running clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mav = '0;
    hs = '0;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_s_arvalid", sav, 0);
    chk("rst_s_rready", srr, 0);
    chk("rst_arready", marr, 0);
    chk("rst_rvalid", mrv, 0);
    @(negedge clk);
    rst = 1'b0;
    busy_m = 0;
    addr_m = 0;
    last = 1;
    own = 0;
    beats = 0;
    len_m = 0;
    tie = 1;
  endtask

  task automatic cycle();
    bit ea, ed;
    for (int n = 0; n < 2; n++) begin
      if (hs[n]) mav[n] = 1'b0;
      if (!mav[n] && (tie || $urandom % 3 == 0)) begin
        mav[n] = 1'b1;
        maddr[n] = {$urandom, $urandom};
        mid[n] = 4'($urandom);
        mlen[n] = 8'($urandom % 4);
        msize[n] = 3'($urandom);
        mburst[n] = 2'($urandom);
      end
      mrr[n] = $urandom % 4 != 0;
    end
    tie = 0;
    s_arready = 1'($urandom);
    s_rvalid = 1'($urandom);
    s_rdata = {$urandom, $urandom};
    s_rid = 4'($urandom);
    s_rresp = 2'($urandom);
    s_rlast = (busy_m && !addr_m) ? (beats == len_m) : 1'($urandom);
    #1;
    ea = busy_m && addr_m;
    ed = busy_m && !addr_m;
    chk("gnt", gnt, busy_m ? (own ? 2 : 1) : 0);
    chk("busy", busy, busy_m);
    chk("s_arvalid", sav, ea ? mav[own] : 0);
    chk("s_araddr", saddr, ea ? maddr[own] : 0);
    chk("s_arid", said, ea ? mid[own] : 0);
    chk("s_arlen", salen, ea ? mlen[own] : 0);
    chk("s_arsize", sasize, ea ? msize[own] : 0);
    chk("s_arburst", saburst, ea ? mburst[own] : 0);
    chk("s_rready", srr, ed ? mrr[own] : 0);
    for (int n = 0; n < 2; n++) begin
      chk("m_arready", marr[n], (ea && own == n) ? s_arready : 0);
      chk("m_rvalid", mrv[n], (ed && own == n) ? s_rvalid : 0);
      chk("m_rdata", mrd[n], (ed && own == n) ? s_rdata : 0);
      chk("m_rid", mrid[n], (ed && own == n) ? s_rid : 0);
      chk("m_rresp", mrresp[n], (ed && own == n) ? s_rresp : 0);
      chk("m_rlast", mrl[n], (ed && own == n) ? s_rlast : 0);
    end
    hs = '0;
    if (!busy_m) begin
      if (|mav) begin
        own = (&mav) ? !last : mav[1];
        last = own;
        busy_m = 1;
        addr_m = 1;
      end
    end else if (addr_m) begin
      if (mav[own] && s_arready) begin
        hs[own] = 1'b1;
        addr_m = 0;
        len_m = int'(mlen[own]);
        beats = 0;
      end
    end else if (s_rvalid && mrr[own]) begin
      if (s_rlast) busy_m = 0;
      else beats++;
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (i % 300 == 299) do_reset();
      else cycle();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/peripheral_axi4_read_arbiter.md
PERIPHERAL_AXI4_READ_ARBITER -- requirements
Module: peripheral_axi4_read_arbiter

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 64, address width of all AR channels.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 64, data width of all R channels.
REQ-003 SHALL have parameter AXI_ID_WIDTH, default 4, ID width of all AR/R channels.
REQ-004 SHALL use one clock and an asynchronous, active-high reset: clk input 1, rising-edge clock.
REQ-005 rst input 1, asynchronous active-high reset.
REQ-006 mN_arvalid / mN_arready (N=0,1) input / output 1 each, master N AR handshake.
REQ-007 mN_araddr input AXI_ADDR_WIDTH, master N read address.
REQ-008 mN_arid input AXI_ID_WIDTH; mN_arlen input 8; mN_arsize input 3; mN_arburst input 2, master N AR attributes.
REQ-009 mN_rvalid output 1; mN_rready input 1, master N R handshake.
REQ-010 mN_rdata output AXI_DATA_WIDTH; mN_rid output AXI_ID_WIDTH; mN_rresp output 2; mN_rlast output 1, master N R payload.
REQ-011 s_arvalid output 1; s_arready input 1; s_araddr, s_arid, s_arlen, s_arsize, s_arburst outputs, widths as REQ-007/008, slave AR channel.
REQ-012 s_rvalid input 1; s_rready output 1; s_rdata, s_rid, s_rresp, s_rlast inputs, widths as REQ-010, slave R channel.
REQ-013 gnt output 2, one-hot current owner (bit N = master N), 0 when idle; busy output 1, high in ADDR or DATA.

Function
REQ-014 SHALL implement FSM IDLE -> ADDR -> DATA -> IDLE; one read burst outstanding at a time.
REQ-015 IDLE: if any mN_arvalid, register owner and go to ADDR next cycle; all arready, rvalid, s_arvalid, s_rready = 0.
REQ-016 Arbitration: single requester wins; both requesting -> master not equal to last_owner wins (round-robin).
REQ-017 last_owner SHALL update to the granted master on the IDLE->ADDR transition.
REQ-018 ADDR: s_arvalid = owner arvalid, s_ar* payload = owner payload, owner arready = s_arready; non-owner arready = 0.
REQ-019 ADDR -> DATA on s_arvalid && s_arready; stays in ADDR otherwise.
REQ-020 DATA: owner rvalid = s_rvalid, owner r* payload = s_r*, s_rready = owner rready; non-owner rvalid = 0.
REQ-021 DATA -> IDLE on s_rvalid && s_rready && s_rlast; a single-beat burst (arlen = 0) completes on its one beat.
REQ-022 Non-owner mN_r* payload SHALL be driven 0; s_ar* payload SHALL be 0 outside ADDR.
REQ-023 Slave R beats arriving outside DATA SHALL not be accepted (s_rready = 0).
REQ-024 Latency: arvalid seen in IDLE at cycle k -> s_arvalid high at cycle k+1; minimum burst occupancy 3 cycles (IDLE, ADDR, DATA).
REQ-025 A request arriving in ADDR/DATA SHALL wait; its arvalid is held by the master per AXI rules.
REQ-026 gnt SHALL be one-hot of owner in ADDR and DATA, 0 in IDLE.

Reset
REQ-027 rst high SHALL force state IDLE, gnt = 0, busy = 0, last_owner = 1 (master 0 wins first tie), all handshake outputs 0, at any time including mid-burst.
REQ-028 After rst deasserts, arbitration SHALL resume on the first rising clk edge.

Verification
REQ-029 Reset, m0_arvalid=1, m0_araddr=0x1000, arlen=3, s_arready=1 -> s_arvalid at cycle 1, 4 beats to m0, busy low after rlast beat.
REQ-030 m0 and m1 arvalid together from reset -> m0 granted first, m1 granted next (gnt 01 then 10).
REQ-031 Both masters hold arvalid for 4 bursts -> grants alternate 0,1,0,1; no starvation.
REQ-032 s_rvalid=1 with owner rready=0 for 5 cycles -> beat held, s_rready=0, no state change; rready=1 -> beat accepted.
REQ-033 rst asserted during beat 2 of arlen=7 burst -> next cycle state IDLE, all handshake outputs 0, gnt 0.
REQ-034 arlen=0, s_rlast=1 on first beat -> return to IDLE after one beat; s_rvalid in IDLE -> s_rready stays 0.
